// File: rtl/des_key_schedule.sv
// DES key-schedule engine: loads one 64-bit key and streams the 16 round
// subkeys (PC-2 of successive CD states) in encrypt or decrypt order.
module des_key_schedule (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        start_i,
  output logic        key_ready_o,
  output logic [47:0] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  subkey_idx_o,
  output logic        subkey_last_o
);

  localparam int unsigned KEY_W    = 64;
  localparam int unsigned CD_W     = 56;
  localparam int unsigned HALF_W   = 28;
  localparam int unsigned SUBKEY_W = 48;
  localparam int unsigned IDX_W    = 4;

  // Bit n set when shift s(n+1) of the schedule is two positions.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  localparam int unsigned PC1_TBL [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // FIPS bit p of the key sits at key[64-p]; cd[n] holds CD position n+1.
  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
    logic [CD_W-1:0] cd;
    cd = '0;
    for (int i = 0; i < CD_W; i++) begin
      cd[6'(i)] = key[6'(KEY_W - PC1_TBL[i])];
    end
    return cd;
  endfunction

  function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
    logic [SUBKEY_W-1:0] sk;
    sk = '0;
    for (int k = 0; k < SUBKEY_W; k++) begin
      sk[6'(SUBKEY_W - 1 - k)] = cd[6'(PC2_TBL[k] - 1)];
    end
    return sk;
  endfunction

  // Rotate C and D independently by one or two FIPS positions.
  function automatic logic [CD_W-1:0] rotate(input logic [CD_W-1:0] cd,
                                             input logic right,
                                             input logic two);
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] d;
    c = cd[HALF_W-1:0];
    d = cd[CD_W-1:HALF_W];
    if (right) begin
      c = two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
      d = two ? {d[25:0], d[27:26]} : {d[26:0], d[27]};
    end else begin
      c = two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
      d = two ? {d[1:0], d[27:2]} : {d[0], d[27:1]};
    end
    return {d, c};
  endfunction

  state_t              state;
  logic [CD_W-1:0]     cd;
  logic                decrypt_q;

  logic [CD_W-1:0]     pc1_c;
  logic [CD_W-1:0]     load_cd_c;
  logic                step_two_c;
  logic [CD_W-1:0]     step_cd_c;
  logic                unused_parity_c;

  // Parity bits (FIPS 8, 16, ..., 64) are dropped by PC-1.
  assign unused_parity_c = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

  // Next CD on load and on each handshake.
  always_comb begin
    pc1_c      = pc1(key_i);
    load_cd_c  = decrypt_i ? pc1_c : rotate(pc1_c, 1'b0, SHIFT2[0]);
    step_two_c = decrypt_q ? SHIFT2[IDX_W'(4'd15 - subkey_idx_o)]
                           : SHIFT2[IDX_W'(subkey_idx_o + 4'd1)];
    step_cd_c  = rotate(cd, decrypt_q, step_two_c);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      cd             <= '0;
      decrypt_q      <= 1'b0;
      subkey_idx_o   <= '0;
      subkey_o       <= '0;
      subkey_valid_o <= 1'b0;
      subkey_last_o  <= 1'b0;
      key_ready_o    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state          <= EMIT;
            decrypt_q      <= decrypt_i;
            cd             <= load_cd_c;
            subkey_o       <= pc2(load_cd_c);
            subkey_idx_o   <= '0;
            subkey_valid_o <= 1'b1;
            subkey_last_o  <= 1'b0;
            key_ready_o    <= 1'b0;
          end
        end
        EMIT: begin
          if (subkey_ready_i) begin
            if (subkey_idx_o == 4'd15) begin
              state          <= IDLE;
              subkey_idx_o   <= '0;
              subkey_o       <= '0;
              subkey_valid_o <= 1'b0;
              subkey_last_o  <= 1'b0;
              key_ready_o    <= 1'b1;
            end else begin
              cd             <= step_cd_c;
              subkey_o       <= pc2(step_cd_c);
              subkey_idx_o   <= IDX_W'(subkey_idx_o + 4'd1);
              subkey_last_o  <= (subkey_idx_o == 4'd14);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [63:0] key_i;
  logic        decrypt_i;
  logic        start_i;
  logic        key_ready_o;
  logic [47:0] subkey_o;
  logic        subkey_valid_o;
  logic        subkey_ready_i;
  logic [3:0]  subkey_idx_o;
  logic        subkey_last_o;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  logic [47:0] exp_k [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  des_key_schedule dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .key_i          (key_i),
    .decrypt_i      (decrypt_i),
    .start_i        (start_i),
    .key_ready_o    (key_ready_o),
    .subkey_o       (subkey_o),
    .subkey_valid_o (subkey_valid_o),
    .subkey_ready_i (subkey_ready_i),
    .subkey_idx_o   (subkey_idx_o),
    .subkey_last_o  (subkey_last_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; first subkey is then visible.
  task automatic launch(input logic [63:0] key, input logic dec);
    key_i     = key;
    decrypt_i = dec;
    start_i   = 1'b1;
    step();
    start_i   = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; key_i = '0; decrypt_i = 1'b0; subkey_ready_i = 1'b0;
    repeat (3) step();
    rst_i = 1'b0;
    total++;
    if ({key_ready_o, subkey_valid_o, subkey_idx_o, subkey_last_o} !== 7'b1000000 ||
        subkey_o !== 48'h0) begin
      bad++;
      $display("FAIL reset_state: rdy=%b vld=%b idx=%0d last=%b sk=%h required rdy=1 vld=0 idx=0 last=0 sk=0",
               key_ready_o, subkey_valid_o, subkey_idx_o, subkey_last_o, subkey_o);
    end
  endtask

  task automatic test_encrypt();
    subkey_ready_i = 1'b1;
    launch(KEY_A, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[k]) begin
        bad++;
        $display("FAIL enc_subkey[%0d]: got %h required %h", k, subkey_o, exp_k[k]);
      end
      total++;
      if ({subkey_valid_o, subkey_idx_o, subkey_last_o, key_ready_o} !==
          {1'b1, 4'(k), (k == 15), 1'b0}) begin
        bad++;
        $display("FAIL enc_ctrl[%0d]: vld=%b idx=%0d last=%b rdy=%b required vld=1 idx=%0d last=%0d rdy=0",
                 k, subkey_valid_o, subkey_idx_o, subkey_last_o, key_ready_o, k, (k == 15));
      end
      step();
    end
    total++;
    if (subkey_valid_o !== 1'b0 || key_ready_o !== 1'b1 || subkey_o !== 48'h0) begin
      bad++;
      $display("FAIL enc_end: vld=%b rdy=%b sk=%h required vld=0 rdy=1 sk=0",
               subkey_valid_o, key_ready_o, subkey_o);
    end
  endtask

  task automatic test_decrypt();
    subkey_ready_i = 1'b1;
    launch(KEY_A, 1'b1);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[15-k] || subkey_idx_o !== 4'(k) || subkey_valid_o !== 1'b1 ||
          subkey_last_o !== (k == 15)) begin
        bad++;
        $display("FAIL dec_subkey[%0d]: got %h idx=%0d vld=%b last=%b required %h idx=%0d",
                 k, subkey_o, subkey_idx_o, subkey_valid_o, subkey_last_o, exp_k[15-k], k);
      end
      step();
    end
    total++;
    if (key_ready_o !== 1'b1 || subkey_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL dec_end: rdy=%b vld=%b required rdy=1 vld=0", key_ready_o, subkey_valid_o);
    end
  endtask

  task automatic test_backpressure();
    int hs = 0;
    int cyc = 0;
    subkey_ready_i = 1'b0;
    launch(KEY_A, 1'b0);
    while (hs < 16 && cyc < 400) begin
      subkey_ready_i = 1'($urandom_range(0, 1));
      total++;
      if (subkey_valid_o !== 1'b1 || subkey_o !== exp_k[hs] || subkey_idx_o !== 4'(hs)) begin
        bad++;
        $display("FAIL bp_hold[%0d]: vld=%b sk=%h idx=%0d required vld=1 sk=%h idx=%0d",
                 hs, subkey_valid_o, subkey_o, subkey_idx_o, exp_k[hs], hs);
      end
      if (subkey_ready_i) hs++;
      step();
      cyc++;
    end
    subkey_ready_i = 1'b1;
    total++;
    if (hs != 16 || subkey_valid_o !== 1'b0 || key_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_count: handshakes=%0d vld=%b rdy=%b required 16 vld=0 rdy=1",
               hs, subkey_valid_o, key_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    subkey_ready_i = 1'b1;
    launch(KEY_A, 1'b0);
    repeat (7) step();
    total++;
    if (subkey_idx_o !== 4'd7) begin
      bad++;
      $display("FAIL rstmid_pre: idx=%0d required 7", subkey_idx_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    total++;
    if (subkey_valid_o !== 1'b0 || key_ready_o !== 1'b1 || subkey_o !== 48'h0 ||
        subkey_idx_o !== 4'd0) begin
      bad++;
      $display("FAIL rstmid_after: vld=%b rdy=%b sk=%h idx=%0d required vld=0 rdy=1 sk=0 idx=0",
               subkey_valid_o, key_ready_o, subkey_o, subkey_idx_o);
    end
    step();
    total++;
    if (subkey_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_quiet: vld=%b required 0", subkey_valid_o);
    end
    launch(KEY_A, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[k] || subkey_idx_o !== 4'(k) || subkey_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_restart[%0d]: got %h idx=%0d vld=%b required %h idx=%0d",
                 k, subkey_o, subkey_idx_o, subkey_valid_o, exp_k[k], k);
      end
      step();
    end
  endtask

  task automatic test_start_busy();
    subkey_ready_i = 1'b1;
    launch(KEY_A, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[k] || subkey_idx_o !== 4'(k)) begin
        bad++;
        $display("FAIL busy_subkey[%0d]: got %h idx=%0d required %h idx=%0d",
                 k, subkey_o, subkey_idx_o, exp_k[k], k);
      end
      // Foreign key at idx 3 and a start alongside the final handshake.
      start_i   = (k == 3) || (k == 15);
      key_i     = KEY_B;
      decrypt_i = 1'b1;
      step();
      start_i   = 1'b0;
    end
    total++;
    if (subkey_valid_o !== 1'b0 || key_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL busy_final_start: vld=%b rdy=%b required vld=0 rdy=1",
               subkey_valid_o, key_ready_o);
    end
    step();
    total++;
    if (subkey_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL busy_no_restart: vld=%b required 0", subkey_valid_o);
    end
  endtask

  task automatic test_parity();
    subkey_ready_i = 1'b1;
    launch(KEY_PAR, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[k]) begin
        bad++;
        $display("FAIL parity_subkey[%0d]: got %h required %h", k, subkey_o, exp_k[k]);
      end
      step();
    end
  endtask

  // Two keys at the minimum 17-cycle spacing: decrypt then encrypt.
  task automatic test_back_to_back();
    subkey_ready_i = 1'b1;
    launch(KEY_A, 1'b1);
    for (int k = 0; k < 16; k++) step();
    total++;
    if (key_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ready: rdy=%b required 1", key_ready_o);
    end
    launch(KEY_A, 1'b0);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (subkey_o !== exp_k[k] || subkey_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL b2b_subkey[%0d]: got %h vld=%b required %h vld=1",
                 k, subkey_o, subkey_valid_o, exp_k[k]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_parity();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES key-schedule engine. Accepts one 64-bit key and streams the 16 round subkeys, one per handshake, to the round datapath.
- Encrypt mode uses left rotations and emits K1..K16. Decrypt mode uses right rotations and emits K16..K1.
- Applies PC-1 on key load and PC-2 on each emitted subkey, per FIPS 46-3.

Parameters:
- None. Shift schedule, PC-1 and PC-2 are fixed by FIPS 46-3.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- key_i  in  64  DES key incl. parity bits; key_i[63] = FIPS bit 1, key_i[0] = FIPS bit 64.
- decrypt_i  in  1  0 = encrypt order (K1 first), 1 = decrypt order (K16 first); sampled on load.
- start_i  in  1  load request; accepted when start_i & key_ready_o.
- key_ready_o  out  1  high when idle and able to accept a key.
- subkey_o  out  48  current subkey; subkey_o[47] = FIPS PC-2 output bit 1.
- subkey_valid_o  out  1  subkey_o is valid.
- subkey_ready_i  in  1  consumer accepts the subkey when subkey_valid_o & subkey_ready_i.
- subkey_idx_o  out  4  emission index 0..15, in emission order.
- subkey_last_o  out  1  high with index 15.

Behaviour:
- Reset: the next edge with rst_i high forces IDLE.
  - key_ready_o = 1; subkey_valid_o = 0; subkey_o = 0; subkey_idx_o = 0; subkey_last_o = 0.
  - The internal 56-bit CD register and mode flag clear to 0.
  - Reset mid-stream aborts the stream; no further subkeys are emitted.
- CD register ordering: cd[n] holds FIPS CD position n+1.
  - C = cd[27:0], D = cd[55:28].
  - One FIPS left rotation of C: cd[27:0] <= {cd[0], cd[27:1]}. D is handled identically.
  - A right rotation is the inverse.
- PC-2 input bit n = FIPS CD position n+1.
- Shift schedule s1..s16 = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Total = 28.
- FSM states: IDLE, EMIT.
- IDLE:
  - key_ready_o = 1; subkey_valid_o = 0; subkey_o = 0.
  - On start_i, at the next edge:
    - Latch decrypt_i.
    - cd <= PC1(key_i) rotated left by s1 when encrypting, or PC1(key_i) unrotated when decrypting (CD16 = CD0).
    - idx <= 0; go to EMIT.
  - Parity bits are ignored; no parity check is performed.
- EMIT:
  - key_ready_o = 0; subkey_valid_o = 1.
  - subkey_o = PC2(cd), combinational from registers only. There is no input-to-output combinational path.
  - On handshake with idx < 15:
    - idx <= idx+1.
    - Encrypt: new index n needs CD(n+1) = CD(n) rotated left by s(n+1).
    - Decrypt: new index n needs CD(16-n) = CD(17-n) rotated right by s(17-n).
  - On handshake with idx = 15: go to IDLE. key_ready_o is high the following cycle.
  - Without a handshake (subkey_ready_i = 0), cd, idx and all outputs hold stable.
- Latency:
  - First subkey is valid 1 cycle after start is accepted.
  - Back-to-back handshakes give 16 subkeys in 16 consecutive cycles.
  - Key-to-key minimum spacing is 17 cycles.
- Simultaneous events:
  - start_i during EMIT is ignored; key_i changes during EMIT have no effect.
  - rst_i takes priority over every handshake.
  - start_i in the same cycle as the final handshake is ignored because key_ready_o is low.

Test Plan:
- Encrypt, key_i = 133457799BBCDFF1, decrypt_i = 0, subkey_ready_i held 1 -> idx 0 subkey_o = 1B02EFFC7072; idx 15 subkey_o = CB3D8B0E17F5 with subkey_last_o = 1; 16 consecutive valid cycles; key_ready_o returns 1 one cycle later.
- Decrypt, same key, decrypt_i = 1 -> idx 0 = CB3D8B0E17F5, idx 15 = 1B02EFFC7072; each idx k equals the encrypt-mode idx 15-k for all 16 values.
- Backpressure: toggle subkey_ready_i pseudo-randomly -> subkey_o and subkey_idx_o stay stable while stalled; exactly 16 handshakes occur; no subkey skipped or repeated.
- Reset mid-stream: assert rst_i one cycle at idx 7 -> next cycle subkey_valid_o = 0, key_ready_o = 1, subkey_o = 0; a new start produces a correct full sequence from idx 0.
- Start while busy: pulse start_i with a different key at idx 3 -> ignored; the stream continues with the original key's subkeys.
- Parity insensitivity: key 133457799BBCDFF1 versus the same key with all 8 parity bits inverted -> identical 16 subkeys.
